// File: rtl/main_fsm.sv
// Multicycle MIPS main controller: Moore FSM that sequences fetch, decode,
// execute and writeback, and drives the datapath enables and mux selects.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic [3:0] state,
    output logic       pcwrite,
    output logic       branch,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       regdst,
    output logic       memtoreg,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] RTYPEEX = 4'd6;
    localparam logic [3:0] RTYPEWB = 4'd7;
    localparam logic [3:0] BEQEX   = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;
    localparam logic [3:0] JEX     = 4'd11;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] next_state;
    logic       nx_pcwrite;
    logic       nx_branch;
    logic       nx_memwrite;
    logic       nx_irwrite;
    logic       nx_regwrite;
    logic       nx_iord;
    logic       nx_alusrca;
    logic [1:0] nx_alusrcb;
    logic       nx_regdst;
    logic       nx_memtoreg;
    logic [1:0] nx_pcsrc;
    logic [1:0] nx_aluop;

    // Next-state selection, then Moore decode of the state about to be entered
    // so the registered outputs line up with the registered state.
    always_comb begin
        next_state  = FETCH;
        nx_pcwrite  = 1'b0;
        nx_branch   = 1'b0;
        nx_memwrite = 1'b0;
        nx_irwrite  = 1'b0;
        nx_regwrite = 1'b0;
        nx_iord     = 1'b0;
        nx_alusrca  = 1'b0;
        nx_alusrcb  = 2'b00;
        nx_regdst   = 1'b0;
        nx_memtoreg = 1'b0;
        nx_pcsrc    = 2'b00;
        nx_aluop    = 2'b00;

        case (state)
            FETCH:   next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = RTYPEEX;
                    OP_BEQ:       next_state = BEQEX;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JEX;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR: begin
                case (op)
                    OP_LW:   next_state = MEMRD;
                    OP_SW:   next_state = MEMWR;
                    default: next_state = FETCH;
                endcase
            end
            MEMRD:   next_state = MEMWB;
            RTYPEEX: next_state = RTYPEWB;
            ADDIEX:  next_state = ADDIWB;
            default: next_state = FETCH;
        endcase

        // Reset lands in FETCH, so the outputs must show FETCH values too.
        if (reset) begin
            next_state = FETCH;
        end

        case (next_state)
            FETCH: begin
                nx_irwrite = 1'b1;
                nx_pcwrite = 1'b1;
                nx_alusrcb = 2'b01;
            end
            DECODE:  nx_alusrcb = 2'b11;
            MEMADR: begin
                nx_alusrca = 1'b1;
                nx_alusrcb = 2'b10;
            end
            MEMRD:   nx_iord = 1'b1;
            MEMWB: begin
                nx_regwrite = 1'b1;
                nx_memtoreg = 1'b1;
            end
            MEMWR: begin
                nx_iord     = 1'b1;
                nx_memwrite = 1'b1;
            end
            RTYPEEX: begin
                nx_alusrca = 1'b1;
                nx_aluop   = 2'b10;
            end
            RTYPEWB: begin
                nx_regwrite = 1'b1;
                nx_regdst   = 1'b1;
            end
            BEQEX: begin
                nx_alusrca = 1'b1;
                nx_aluop   = 2'b01;
                nx_pcsrc   = 2'b01;
                nx_branch  = 1'b1;
            end
            ADDIEX: begin
                nx_alusrca = 1'b1;
                nx_alusrcb = 2'b10;
            end
            ADDIWB:  nx_regwrite = 1'b1;
            JEX: begin
                nx_pcwrite = 1'b1;
                nx_pcsrc   = 2'b10;
            end
            default: ;
        endcase
    end

    // State and output registers; outputs already reflect reset via the decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
        pcwrite  <= nx_pcwrite;
        branch   <= nx_branch;
        memwrite <= nx_memwrite;
        irwrite  <= nx_irwrite;
        regwrite <= nx_regwrite;
        iord     <= nx_iord;
        alusrca  <= nx_alusrca;
        alusrcb  <= nx_alusrcb;
        regdst   <= nx_regdst;
        memtoreg <= nx_memtoreg;
        pcsrc    <= nx_pcsrc;
        aluop    <= nx_aluop;
    end

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: a per-opcode state-route model plus a per-state control
// table checked every cycle, and literal state-trace / CPI checks per instruction.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [3:0] state;
    logic       pcwrite, branch, memwrite, irwrite, regwrite, iord, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       regdst, memtoreg;

    int total = 0;
    int bad   = 0;

    main_fsm dut (
        .clk(clk), .reset(reset), .op(op), .state(state),
        .pcwrite(pcwrite), .branch(branch), .memwrite(memwrite),
        .irwrite(irwrite), .regwrite(regwrite), .iord(iord),
        .alusrca(alusrca), .alusrcb(alusrcb), .regdst(regdst),
        .memtoreg(memtoreg), .pcsrc(pcsrc), .aluop(aluop)
    );

    always #5 clk = ~clk;

    // Control vector: pcwrite,branch,memwrite,irwrite,regwrite,iord,alusrca,
    // alusrcb[1:0],regdst,memtoreg,pcsrc[1:0],aluop[1:0]
    logic [14:0] ctl;
    assign ctl = {pcwrite, branch, memwrite, irwrite, regwrite, iord, alusrca,
                  alusrcb, regdst, memtoreg, pcsrc, aluop};

    // Expected control vector for each state, written out from the state table.
    function automatic logic [14:0] exp_ctl(input int s);
        logic pw, br, mw, ir, rw, io, sa, rd, mr;
        logic [1:0] sb, ps, ao;
        pw = 0; br = 0; mw = 0; ir = 0; rw = 0; io = 0; sa = 0; rd = 0; mr = 0;
        sb = 2'b00; ps = 2'b00; ao = 2'b00;
        case (s)
            0:  begin ir = 1; pw = 1; sb = 2'b01; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  io = 1;
            4:  begin rw = 1; mr = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pw, br, mw, ir, rw, io, sa, sb, rd, mr, ps, ao};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: on leaving FETCH, the opcode picks the list of states still to visit.
    int m_state = 0;
    bit m_valid = 1'b0;
    int route[$];

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            route.delete();
            m_state = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_state == 0) begin
                case (op)
                    6'b100011: route = '{1, 2, 3, 4};
                    6'b101011: route = '{1, 2, 5};
                    6'b000000: route = '{1, 6, 7};
                    6'b000100: route = '{1, 8};
                    6'b001000: route = '{1, 9, 10};
                    6'b000010: route = '{1, 11};
                    default:   route = '{1};
                endcase
            end
            if (route.size() > 0) m_state = route.pop_front();
            else                  m_state = 0;
        end
    end

    // Every-cycle compare, half a period away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("state", 32'(state), 32'(m_state));
            check("ctl", 32'(ctl), 32'(exp_ctl(m_state)));
        end
    end

    // Runs one instruction from FETCH; checks the observed state trace and CPI.
    task automatic run_instr(input logic [5:0] opc, input logic [31:0] exp_seq, input int exp_cpi);
        logic [31:0] seq;
        int n;
        seq = 0;
        n = 0;
        op = opc;
        do begin
            @(posedge clk);
            #1;
            seq = (seq << 4) | 32'(state);
            n++;
        end while (state != 4'd0 && n < 12);
        check("trace", seq, exp_seq);
        check("cpi", 32'(n), 32'(exp_cpi));
    endtask

    initial begin
        int n;
        reset = 1'b1;
        op = 6'bxxxxxx;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ctl", 32'(ctl), 32'(15'b100100001000000));
        reset = 1'b0;

        run_instr(6'b100011, 32'h12340, 5);   // lw
        run_instr(6'b101011, 32'h1250, 4);    // sw
        run_instr(6'b000000, 32'h1670, 4);    // R-type
        run_instr(6'b000100, 32'h180, 3);     // beq
        run_instr(6'b000010, 32'h1b0, 3);     // j
        run_instr(6'b001000, 32'h19a0, 4);    // addi
        run_instr(6'b111111, 32'h10, 2);      // illegal

        // Reset while a load sits in MEMRD: abandoned without a register write.
        op = 6'b100011;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (state != 4'd3 && n < 12);
        check("reach_memrd", 32'(state), 32'd3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_regwrite", 32'(regwrite), 32'd0);
        check("midrst_ctl", 32'(ctl), 32'(15'b100100001000000));
        reset = 1'b0;

        run_instr(6'b000000, 32'h1670, 4);    // R-type after reset
        run_instr(6'b100011, 32'h12340, 5);   // lw after reset
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
